// File: rtl/key_debounce.sv
// Multi-key debouncer: two-flop synchronizer, shared sample-tick prescaler and
// per-key stability filter producing a clean level plus press/release pulses.
module key_debounce #(
  parameter int N_KEYS         = 3,
  parameter int TICK_DIV       = 50000,
  parameter int DEBOUNCE_TICKS = 20,
  parameter bit KEY_ACTIVE_LOW = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_KEYS-1:0] key_raw,
  output logic [N_KEYS-1:0] key_level,
  output logic [N_KEYS-1:0] key_down,
  output logic [N_KEYS-1:0] key_up
);

  localparam int CW = $clog2(DEBOUNCE_TICKS + 1);
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] DIV_LAST = PW'(TICK_DIV - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_TICKS - 1);
  localparam logic [N_KEYS-1:0] RELEASED = {N_KEYS{KEY_ACTIVE_LOW}};

  logic [N_KEYS-1:0] sync1_q, sync2_q;
  logic [N_KEYS-1:0] s;
  logic [PW-1:0]     div_q, div_d;
  logic              tick;

  logic [N_KEYS-1:0][CW-1:0] cnt_q, cnt_d;
  logic [N_KEYS-1:0]         level_q, level_d;
  logic [N_KEYS-1:0]         down_q, down_d;
  logic [N_KEYS-1:0]         up_q, up_d;

  // Synchronizer resets to the released polarity so reset release never looks like a press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= RELEASED;
      sync2_q <= RELEASED;
    end else begin
      sync1_q <= key_raw;
      sync2_q <= sync1_q;
    end
  end

  assign s     = KEY_ACTIVE_LOW ? ~sync2_q : sync2_q;
  assign tick  = (div_q == DIV_LAST);
  assign div_d = tick ? '0 : div_q + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q <= '0;
    end else begin
      div_q <= div_d;
    end
  end

  // A nonzero count means a change is pending; any tick that sees the old level aborts it.
  always_comb begin
    level_d = level_q;
    down_d  = '0;
    up_d    = '0;
    cnt_d   = cnt_q;
    for (int i = 0; i < N_KEYS; i++) begin
      if (tick) begin
        if (s[i] == level_q[i]) begin
          cnt_d[i] = '0;
        end else if (cnt_q[i] == CNT_LAST) begin
          cnt_d[i]   = '0;
          level_d[i] = s[i];
          down_d[i]  = s[i];
          up_d[i]    = ~s[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      level_q <= '0;
      down_q  <= '0;
      up_q    <= '0;
    end else begin
      cnt_q   <= cnt_d;
      level_q <= level_d;
      down_q  <= down_d;
      up_q    <= up_d;
    end
  end

  assign key_level = level_q;
  assign key_down  = down_q;
  assign key_up    = up_q;

endmodule

// File: tb/tb_key_debounce.sv
// Scoreboard bench for key_debounce: expected pulse events are queued when a
// key is driven and compared against the pulses the monitor captures.
module tb_key_debounce;

  localparam int TD = 4;
  localparam int DT = 3;

  logic       clk;
  logic       rst_n;
  logic [2:0] key_raw;
  logic [2:0] keyLevel;
  logic [2:0] keyDown;
  logic [2:0] keyUp;

  typedef struct {
    int       cyc;
    logic [2:0] down;
    logic [2:0] up;
    logic [2:0] level;
  } event_t;

  event_t     expQ[$];
  event_t     obsQ[$];
  event_t     monEv;
  int         total = 0;
  int         bad = 0;
  int         cyc = 0;
  int         relCyc = 0;
  logic [2:0] expLevel = 3'b000;

  key_debounce #(
    .N_KEYS(3),
    .TICK_DIV(TD),
    .DEBOUNCE_TICKS(DT),
    .KEY_ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .key_raw(key_raw),
    .key_level(keyLevel),
    .key_down(keyDown),
    .key_up(keyUp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Capture every pulse with the cycle it appeared in, sampled on the falling edge.
  always @(negedge clk) begin
    if ((keyDown | keyUp) !== 3'b000) begin
      monEv.cyc   = cyc;
      monEv.down  = keyDown;
      monEv.up    = keyUp;
      monEv.level = keyLevel;
      obsQ.push_back(monEv);
    end
  end

  // Sample ticks fall on edges relCyc+4, relCyc+8, ... after reset release.
  function automatic int nextTick(input int e);
    int d;
    d = e - relCyc;
    if (d < 1) d = 1;
    return relCyc + ((d + TD - 1) / TD) * TD;
  endfunction

  function automatic event_t mkEv(input int c, input logic [2:0] dn,
                                  input logic [2:0] u, input logic [2:0] lv);
    event_t ev;
    ev.cyc = c; ev.down = dn; ev.up = u; ev.level = lv;
    return ev;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    key_raw = 3'b111;
    repeat (3) @(negedge clk);
    total++;
    if ({keyLevel, keyDown, keyUp} !== 9'b0) begin
      bad++;
      $display("[TB] FAIL reset_hold: got level=%b down=%b up=%b, required all 0", keyLevel, keyDown, keyUp);
    end
    rst_n = 1'b1;
    relCyc = cyc;
    repeat (100) begin
      @(negedge clk);
      total++;
      if ({keyLevel, keyDown, keyUp} !== 9'b0) begin
        bad++;
        $display("[TB] FAIL reset_idle: cyc=%0d got level=%b down=%b up=%b, required all 0", cyc, keyLevel, keyDown, keyUp);
      end
    end
    total++;
    if (obsQ.size() != 0) begin
      bad++;
      $display("[TB] FAIL reset_pulses: got %0d pulse events, required 0", obsQ.size());
      obsQ.delete();
    end
  endtask

  task automatic test_press();
    event_t e, o;
    int c0;
    @(negedge clk);
    c0 = cyc;
    key_raw[0] = 1'b0;
    expLevel[0] = 1'b1;
    expQ.push_back(mkEv(nextTick(c0 + 3) + (DT - 1) * TD, 3'b001, 3'b000, expLevel));
    repeat (20) @(negedge clk);
    while (expQ.size() > 0) begin
      e = expQ.pop_front();
      total++;
      if (obsQ.size() == 0) begin
        bad++;
        $display("[TB] FAIL press_missing: got no pulse, required one at cyc=%0d", e.cyc);
      end else begin
        o = obsQ.pop_front();
        if (o.cyc !== e.cyc || o.down !== e.down || o.up !== e.up || o.level !== e.level) begin
          bad++;
          $display("[TB] FAIL press_event: got cyc=%0d down=%b up=%b level=%b, required cyc=%0d down=%b up=%b level=%b (delay %0d)",
                   o.cyc, o.down, o.up, o.level, e.cyc, e.down, e.up, e.level, o.cyc - c0);
        end
      end
    end
    total++;
    if (obsQ.size() != 0 || keyLevel !== expLevel) begin
      bad++;
      $display("[TB] FAIL press_after: got %0d extra events level=%b, required 0 extra level=%b", obsQ.size(), keyLevel, expLevel);
      obsQ.delete();
    end
  endtask

  task automatic test_glitch();
    for (int r = 0; r < 8; r++) begin
      @(negedge clk);
      key_raw[1] = 1'b0;
      repeat (3) @(negedge clk);
      key_raw[1] = 1'b1;
      repeat (4) @(negedge clk);
    end
    repeat (16) @(negedge clk);
    total++;
    if (obsQ.size() != 0) begin
      bad++;
      $display("[TB] FAIL glitch_pulses: got %0d pulse events, required 0", obsQ.size());
      obsQ.delete();
    end
    total++;
    if (keyLevel !== expLevel) begin
      bad++;
      $display("[TB] FAIL glitch_level: got level=%b, required %b", keyLevel, expLevel);
    end
  endtask

  task automatic test_bounce();
    event_t e, o;
    int c0;
    @(negedge clk);
    c0 = cyc;
    key_raw[2] = 1'b0;
    expLevel[2] = 1'b1;
    expQ.push_back(mkEv(nextTick(c0 + 3) + (DT - 1) * TD, 3'b100, 3'b000, expLevel));
    repeat (20) @(negedge clk);
    c0 = cyc;
    key_raw[2] = 1'b1;
    repeat (6) @(negedge clk);
    key_raw[2] = 1'b0;
    repeat (4) @(negedge clk);
    key_raw[2] = 1'b1;
    expQ.push_back(mkEv(nextTick(c0 + 9) + DT * TD, 3'b000, 3'b100, expLevel & 3'b011));
    expLevel[2] = 1'b0;
    repeat (25) @(negedge clk);
    while (expQ.size() > 0) begin
      e = expQ.pop_front();
      total++;
      if (obsQ.size() == 0) begin
        bad++;
        $display("[TB] FAIL bounce_missing: got no pulse, required one at cyc=%0d", e.cyc);
      end else begin
        o = obsQ.pop_front();
        if (o.cyc !== e.cyc || o.down !== e.down || o.up !== e.up || o.level !== e.level) begin
          bad++;
          $display("[TB] FAIL bounce_event: got cyc=%0d down=%b up=%b level=%b, required cyc=%0d down=%b up=%b level=%b",
                   o.cyc, o.down, o.up, o.level, e.cyc, e.down, e.up, e.level);
        end
      end
    end
    total++;
    if (obsQ.size() != 0 || keyLevel !== expLevel) begin
      bad++;
      $display("[TB] FAIL bounce_after: got %0d extra events level=%b, required 0 extra level=%b", obsQ.size(), keyLevel, expLevel);
      obsQ.delete();
    end
  endtask

  task automatic test_simultaneous();
    event_t e, o;
    int c0;
    @(negedge clk);
    c0 = cyc;
    key_raw[0] = 1'b1;
    expLevel[0] = 1'b0;
    expQ.push_back(mkEv(nextTick(c0 + 3) + (DT - 1) * TD, 3'b000, 3'b001, expLevel));
    repeat (20) @(negedge clk);
    c0 = cyc;
    key_raw[0] = 1'b0;
    key_raw[2] = 1'b0;
    expLevel = expLevel | 3'b101;
    expQ.push_back(mkEv(nextTick(c0 + 3) + (DT - 1) * TD, 3'b101, 3'b000, expLevel));
    repeat (20) @(negedge clk);
    while (expQ.size() > 0) begin
      e = expQ.pop_front();
      total++;
      if (obsQ.size() == 0) begin
        bad++;
        $display("[TB] FAIL simul_missing: got no pulse, required one at cyc=%0d", e.cyc);
      end else begin
        o = obsQ.pop_front();
        if (o.cyc !== e.cyc || o.down !== e.down || o.up !== e.up || o.level !== e.level) begin
          bad++;
          $display("[TB] FAIL simul_event: got cyc=%0d down=%b up=%b level=%b, required cyc=%0d down=%b up=%b level=%b",
                   o.cyc, o.down, o.up, o.level, e.cyc, e.down, e.up, e.level);
        end
      end
    end
    total++;
    if (obsQ.size() != 0 || keyLevel !== expLevel) begin
      bad++;
      $display("[TB] FAIL simul_after: got %0d extra events level=%b, required 0 extra level=%b", obsQ.size(), keyLevel, expLevel);
      obsQ.delete();
    end
  endtask

  task automatic test_reset_mid_count();
    event_t e, o;
    int c0, t1;
    @(negedge clk);
    c0 = cyc;
    key_raw[0] = 1'b1;
    key_raw[2] = 1'b1;
    expLevel = 3'b000;
    expQ.push_back(mkEv(nextTick(c0 + 3) + (DT - 1) * TD, 3'b000, 3'b101, expLevel));
    repeat (20) @(negedge clk);
    c0 = cyc;
    key_raw[0] = 1'b0;
    t1 = nextTick(c0 + 3);
    while (cyc < t1 + TD + 1) @(negedge clk);
    rst_n = 1'b0;
    #1;
    total++;
    if ({keyLevel, keyDown, keyUp} !== 9'b0) begin
      bad++;
      $display("[TB] FAIL midreset_now: got level=%b down=%b up=%b, required all 0", keyLevel, keyDown, keyUp);
    end
    repeat (5) begin
      @(negedge clk);
      total++;
      if ({keyLevel, keyDown, keyUp} !== 9'b0) begin
        bad++;
        $display("[TB] FAIL midreset_hold: got level=%b down=%b up=%b, required all 0", keyLevel, keyDown, keyUp);
      end
    end
    rst_n = 1'b1;
    relCyc = cyc;
    expLevel[0] = 1'b1;
    expQ.push_back(mkEv(nextTick(relCyc + 3) + (DT - 1) * TD, 3'b001, 3'b000, expLevel));
    repeat (20) @(negedge clk);
    while (expQ.size() > 0) begin
      e = expQ.pop_front();
      total++;
      if (obsQ.size() == 0) begin
        bad++;
        $display("[TB] FAIL midreset_missing: got no pulse, required one at cyc=%0d", e.cyc);
      end else begin
        o = obsQ.pop_front();
        if (o.cyc !== e.cyc || o.down !== e.down || o.up !== e.up || o.level !== e.level) begin
          bad++;
          $display("[TB] FAIL midreset_event: got cyc=%0d down=%b up=%b level=%b, required cyc=%0d down=%b up=%b level=%b",
                   o.cyc, o.down, o.up, o.level, e.cyc, e.down, e.up, e.level);
        end
      end
    end
    total++;
    if (obsQ.size() != 0 || keyLevel !== expLevel) begin
      bad++;
      $display("[TB] FAIL midreset_after: got %0d extra events level=%b, required 0 extra level=%b", obsQ.size(), keyLevel, expLevel);
      obsQ.delete();
    end
  endtask

  initial begin
    rst_n = 1'b0;
    key_raw = 3'b111;
    test_reset();
    test_press();
    test_glitch();
    test_bounce();
    test_simultaneous();
    test_reset_mid_count();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/key_debounce.md
Name: key_debounce

Overview:
- Multi-key debouncer and edge-pulse generator between the board push-buttons and the stopwatch key-control stage.
- Synchronizes raw, bouncing, asynchronous button inputs to clk and filters them against a tick-based stability window.
- Emits a clean debounced level plus one-clk-cycle press and release pulses per key.
- key_down[0..2] drives the control stage's start, pause and load key inputs, giving it exactly one clean rising edge per physical press.

Parameters:
- N_KEYS, 3, number of independent key channels.
- TICK_DIV, 50000, clk cycles per sample tick (1 kHz at 50 MHz).
- DEBOUNCE_TICKS, 20, consecutive agreeing ticks required to accept a new level (20 ms default).
- KEY_ACTIVE_LOW, 1, 1 means raw key reads 0 when pressed.

Ports:
- clk, input, 1, system clock.
- rst_n, input, 1, asynchronous active-low reset.
- key_raw, input, N_KEYS, raw button pins; asynchronous and bouncing.
- key_level, output, N_KEYS, debounced state; 1 = pressed, regardless of KEY_ACTIVE_LOW.
- key_down, output, N_KEYS, one-clk pulse on accepted press.
- key_up, output, N_KEYS, one-clk pulse on accepted release.

Behaviour:
- Reset (async assert, sync-safe deassert by design of upstream reset) sets:
  - key_level = 0, key_down = 0, key_up = 0.
  - Prescaler and all per-key counters = 0.
  - Both synchronizer flops = released polarity (all 1s when KEY_ACTIVE_LOW=1), so reset release never fakes a press.
- Synchronizer:
  - 2-flop chain per key, then polarity-normalized to s[i] (1 = pressed).
  - s[i] lags key_raw by 2 clk edges.
- Prescaler:
  - Counts 0..TICK_DIV-1, wraps, and asserts internal tick for one clk when the count equals TICK_DIV-1.
  - The first tick occurs TICK_DIV clks after reset release.
  - TICK_DIV=1 means tick every cycle.
- Per-key filter (independent per key; states STABLE and CHANGING, encoded by cnt != 0):
  - Non-tick cycle: state holds, key_down/key_up = 0.
  - Tick with s[i] == key_level[i]: cnt[i] <= 0 (any bounce back aborts the pending change).
  - Tick with s[i] != key_level[i] and cnt[i]+1 < DEBOUNCE_TICKS: cnt[i] <= cnt[i]+1.
  - Tick with s[i] != key_level[i] and cnt[i]+1 == DEBOUNCE_TICKS: key_level[i] <= s[i], cnt[i] <= 0, and key_down[i] (new level 1) or key_up[i] (new level 0) is registered high for exactly that one following clk cycle.
- Counter width: clog2(DEBOUNCE_TICKS+1); it never exceeds DEBOUNCE_TICKS-1.
- DEBOUNCE_TICKS=1: a change is accepted on the first tick that sees it.
- Latency: a clean edge is accepted on the DEBOUNCE_TICKS-th tick at which s has the new value. Total delay is between 2+(DEBOUNCE_TICKS-1)*TICK_DIV+1 and 2+DEBOUNCE_TICKS*TICK_DIV clks.
- Glitch rejection:
  - Bounces shorter than one tick period are not sampled.
  - Any tick sampling the old level restarts the count.
- Key held through reset release: treated as a new press, so key_down fires after the debounce window.
- Simultaneous events:
  - Keys are fully independent; several key_down/key_up bits may pulse in the same cycle.
  - key_down[i] and key_up[i] are never both 1.
  - The outputs never pulse on consecutive cycles for the same key, because a level change needs at least DEBOUNCE_TICKS ticks.
- Reset mid-count: all state clears immediately, with no pulse on or after reset.
- Outputs are registered; there is no combinational path from key_raw to any output.

Test Plan (TICK_DIV=4, DEBOUNCE_TICKS=3, KEY_ACTIVE_LOW=1 unless stated):
- Reset with key_raw=3'b111, run 100 clks -> key_level=0, key_down=0, key_up=0 throughout.
- key_raw[0] 1->0 cleanly, held -> exactly one key_down[0] pulse of 1 clk, 11..14 clks after the edge; key_level[0]=1 from the same cycle; no key_up.
- key_raw[1] low pulses of 3 clks repeated every 8 clks for 64 clks -> no key_down[1]; key_level[1] stays 0.
- Press key 2, then release with a 1-tick bounce back low after 6 clks -> a single key_up[2] pulse only after 3 consecutive high ticks; count restarts at the bounce.
- Keys 0 and 2 pressed on the same clk -> key_down[0] and key_down[2] pulse in the same cycle.
- rst_n asserted while key 0 has cnt=2 -> outputs 0 immediately. With key still low at release, key_down[0] is pulsed only after a full 3-tick window.
